stack_ctrl: RTL



---
 rtl/stack_ctrl_if.sv | 30 +++
 rtl/stack_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl_if.sv
// Button/data/status bundle between the board-side driver and the stack controller.
interface stack_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
);
    logic                     push_btn;
    logic                     pop_btn;
    logic [WIDTH-1:0]         din;
    logic [WIDTH-1:0]         top;
    logic [2:0]               count;
    logic                     full;
    logic                     empty;
    logic                     busy;
    logic                     op_done;
    logic                     err_overflow;
    logic                     err_underflow;
    logic [DEPTH*WIDTH-1:0]   stack_flat;

    modport master (
        output push_btn, pop_btn, din,
        input  top, count, full, empty, busy, op_done,
               err_overflow, err_underflow, stack_flat
    );

    modport slave (
        input  push_btn, pop_btn, din,
        output top, count, full, empty, busy, op_done,
               err_overflow, err_underflow, stack_flat
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: one push/pop per button press, owns storage, count and sticky error flags.
module stack_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    stack_ctrl_if.slave  bus
);

    localparam logic [2:0] FULL_COUNT = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        POP,
        WAIT_REL
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [WIDTH-1:0] din_q;
    logic [2:0]       count_q;
    logic             op_done_q;
    logic             err_ov_q;
    logic             err_un_q;

    logic             capture;
    logic             do_push;
    logic             do_pop;
    logic             push_fail;
    logic             pop_fail;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first; a missing
    // assignment on any branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        push_fail  = 1'b0;
        pop_fail   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.push_btn && !bus.pop_btn) begin
                    state_next = PUSH;
                    capture    = 1'b1;
                end else if (bus.pop_btn && !bus.push_btn) begin
                    state_next = POP;
                end else if (bus.push_btn && bus.pop_btn) begin
                    state_next = WAIT_REL;
                end
            end
            PUSH: begin
                if (count_q < FULL_COUNT) begin
                    do_push = 1'b1;
                end else begin
                    push_fail = 1'b1;
                end
                state_next = WAIT_REL;
            end
            POP: begin
                if (count_q != 3'd0) begin
                    do_pop = 1'b1;
                end else begin
                    pop_fail = 1'b1;
                end
                state_next = WAIT_REL;
            end
            WAIT_REL: begin
                // Hold here until both buttons are released: no auto-repeat.
                if (!bus.push_btn && !bus.pop_btn) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the storage array is reset explicitly because vacant entries must
    // read back as zero and a reset must discard any in-flight write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            din_q     <= '0;
            count_q   <= 3'd0;
            op_done_q <= 1'b0;
            err_ov_q  <= 1'b0;
            err_un_q  <= 1'b0;
        end else begin
            if (capture) begin
                din_q <= bus.din;
            end

            op_done_q <= do_push | do_pop;

            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && count_q == 3'(i)) begin
                    entries[i] <= din_q;
                end
                if (do_pop && count_q == 3'(i + 1)) begin
                    entries[i] <= '0;
                end
            end

            if (do_push) begin
                count_q <= count_q + 3'd1;
            end else if (do_pop) begin
                count_q <= count_q - 3'd1;
            end

            // A successful operation clears both flags; failures only ever set them.
            if (do_push || do_pop) begin
                err_ov_q <= 1'b0;
                err_un_q <= 1'b0;
            end else begin
                if (push_fail) begin
                    err_ov_q <= 1'b1;
                end
                if (pop_fail) begin
                    err_un_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == 3'(i + 1)) begin
                bus.top = entries[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign bus.stack_flat[g*WIDTH +: WIDTH] = entries[g];
    end

    assign bus.count         = count_q;
    assign bus.full          = (count_q == FULL_COUNT);
    assign bus.empty         = (count_q == 3'd0);
    assign bus.busy          = (state != IDLE);
    assign bus.op_done       = op_done_q;
    assign bus.err_overflow  = err_ov_q;
    assign bus.err_underflow = err_un_q;

endmodule
